// File: rtl/alu_decoder.sv
// Second-level RV32I ALU control decoder: maps ALUop/opcode/funct3/funct7[5] to the
// 3-bit ALUControl code, optionally registered for pipeline staging.
module alu_decoder #(
    parameter int unsigned REG_OUT      = 1,
    parameter logic [2:0]  DEFAULT_CTRL = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic [1:0] ALUop,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    localparam int unsigned CTRL_W = 3;

    localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(3'b000);
    localparam logic [CTRL_W-1:0] ALU_SUB = CTRL_W'(3'b001);
    localparam logic [CTRL_W-1:0] ALU_AND = CTRL_W'(3'b010);
    localparam logic [CTRL_W-1:0] ALU_OR  = CTRL_W'(3'b011);
    localparam logic [CTRL_W-1:0] ALU_XOR = CTRL_W'(3'b100);
    localparam logic [CTRL_W-1:0] ALU_SLT = CTRL_W'(3'b101);
    localparam logic [CTRL_W-1:0] ALU_SLL = CTRL_W'(3'b110);
    localparam logic [CTRL_W-1:0] ALU_SRL = CTRL_W'(3'b111);

    logic [CTRL_W-1:0] ctrl_c;
    logic              illegal_c;

    // Only op[5] (R-type vs I-type) matters to the decode.
    logic op_unused_c;
    assign op_unused_c = ^{op[6], op[4:0]};

    // Decode; defaults give a defined result for every input combination.
    always_comb begin
        ctrl_c    = DEFAULT_CTRL;
        illegal_c = 1'b0;
        case (ALUop)
            2'b00: ctrl_c = ALU_ADD;
            2'b01: ctrl_c = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000: ctrl_c = ({op[5], funct7} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b001: ctrl_c = ALU_SLL;
                    3'b010: ctrl_c = ALU_SLT;
                    3'b100: ctrl_c = ALU_XOR;
                    3'b101: begin
                        // SRA has no ALU encoding
                        if (funct7) begin
                            ctrl_c    = DEFAULT_CTRL;
                            illegal_c = 1'b1;
                        end else begin
                            ctrl_c = ALU_SRL;
                        end
                    end
                    3'b110: ctrl_c = ALU_OR;
                    3'b111: ctrl_c = ALU_AND;
                    default: begin
                        ctrl_c    = DEFAULT_CTRL;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl_c    = DEFAULT_CTRL;
                illegal_c = 1'b1;
            end
        endcase
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ALUControl <= '0;
                    illegal    <= 1'b0;
                end else begin
                    ALUControl <= ctrl_c;
                    illegal    <= illegal_c;
                end
            end
        end else begin : g_comb
            logic clk_unused_c;
            assign clk_unused_c = clk;
            assign ALUControl   = rst_n ? ctrl_c : '0;
            assign illegal      = rst_n & illegal_c;
        end
    endgenerate

endmodule

// File: tb/tb_alu_decoder.sv
// Directed bench for alu_decoder (registered output mode): hand-computed vectors
// checked with immediate assertions one cycle after each input change.
module tb_alu_decoder;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic [1:0] ALUop;
    logic [2:0] ALUControl;
    logic       illegal;

    int n_total = 0;
    int n_pass  = 0;

    alu_decoder #(.REG_OUT(1), .DEFAULT_CTRL(3'b000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .funct3    (funct3),
        .funct7    (funct7),
        .ALUop     (ALUop),
        .ALUControl(ALUControl),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] ec, input logic ei);
        n_total++;
        assert ({ALUControl, illegal} === {ec, ei}) n_pass++;
        else $error("FAIL %s: got ctrl=%b illegal=%b, expected ctrl=%b illegal=%b",
                    tag, ALUControl, illegal, ec, ei);
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [1:0] a);
        op     = o;
        funct3 = f3;
        funct7 = f7;
        ALUop  = a;
    endtask

    // Drive inputs, let one rising edge capture them, then check.
    task automatic step(input string tag, input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic [1:0] a,
                        input logic [2:0] ec, input logic ei);
        drive(o, f3, f7, a);
        @(posedge clk);
        #1;
        chk(tag, ec, ei);
    endtask

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    initial begin
        // Reset with inputs that would decode as illegal
        rst_n = 1'b0;
        drive(7'h7F, 3'b011, 1'b1, 2'b11);
        #2;
        chk("reset_async", 3'b000, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_held", 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step("aluop00_add", 7'h00, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0);
        step("aluop01_sub", 7'h00, 3'b000, 1'b0, 2'b01, 3'b001, 1'b0);

        // Output must not change before the next capturing edge
        drive(7'h00, 3'b000, 1'b0, 2'b00);
        #1;
        chk("latency_hold", 3'b001, 1'b0);
        @(posedge clk);
        #1;
        chk("latency_update", 3'b000, 1'b0);

        step("f000_rtype_sub", OP_R,        3'b000, 1'b1, 2'b10, 3'b001, 1'b0);
        step("f000_addi_b30",  OP_I,        3'b000, 1'b1, 2'b10, 3'b000, 1'b0);
        step("f000_op5_f7_0",  7'b0100000,  3'b000, 1'b0, 2'b10, 3'b000, 1'b0);
        step("f000_rtype_add", OP_R,        3'b000, 1'b0, 2'b10, 3'b000, 1'b0);

        step("f111_and", OP_R, 3'b111, 1'b0, 2'b10, 3'b010, 1'b0);
        step("f110_or",  OP_R, 3'b110, 1'b0, 2'b10, 3'b011, 1'b0);
        step("f010_slt", OP_R, 3'b010, 1'b0, 2'b10, 3'b101, 1'b0);
        step("f100_xor", OP_R, 3'b100, 1'b0, 2'b10, 3'b100, 1'b0);
        step("f001_sll", OP_R, 3'b001, 1'b0, 2'b10, 3'b110, 1'b0);
        step("f101_srl", OP_R, 3'b101, 1'b0, 2'b10, 3'b111, 1'b0);

        step("f011_sltu_illegal", OP_R, 3'b011, 1'b0, 2'b10, 3'b000, 1'b1);
        step("f101_sra_illegal",  OP_R, 3'b101, 1'b1, 2'b10, 3'b000, 1'b1);
        step("aluop11_illegal",   OP_R, 3'b111, 1'b0, 2'b11, 3'b000, 1'b1);
        step("illegal_clears",    OP_R, 3'b100, 1'b0, 2'b10, 3'b100, 1'b0);

        step("dontcare_op_and", 7'h7F, 3'b111, 1'b1, 2'b10, 3'b010, 1'b0);
        step("aluop00_ignores", 7'h7F, 3'b011, 1'b1, 2'b00, 3'b000, 1'b0);
        step("aluop01_ignores", 7'h7F, 3'b101, 1'b1, 2'b01, 3'b001, 1'b0);

        // Asynchronous reset mid-stream discards the held result
        step("pre_reset_srl", OP_R, 3'b101, 1'b0, 2'b10, 3'b111, 1'b0);
        drive(OP_R, 3'b100, 1'b0, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midstream_reset", 3'b000, 1'b0);
        @(posedge clk);
        #1;
        chk("midstream_reset_held", 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_capture", 3'b100, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
